ram_fill_arbiter: RTL and testbench
===================================

// Module: ram_fill_arbiter
// PURPOSE
//  Owns the single read/write port of the data RAM and shares it between the CPU
//  memory stage and a built-in fill engine. The fill engine writes a constant over
//  an address range, wrapping at the top of the RAM. It runs automatically after
//  reset (full clear) and on software request via start. It sits between the MEM
//  stage and the ram instance; the display read port is untouched.
// PARAMETERS
//  ADDR_WIDTH      10  RAM address width; RAM depth = 2**ADDR_WIDTH words.
//  DATA_WIDTH      32  RAM word width.
//  MAX_WAIT        3   consecutive CPU-won cycles tolerated before the fill gets one forced slot (>=1).
//  CLEAR_ON_RESET  1   1: after rst, zero-fill the whole RAM; 0: go idle after rst.
// PORTS
//  clk       in   1              clock; all state updates on posedge.
//  rst       in   1              synchronous, active-high reset.
//  start     in   1              fill request; sampled only in IDLE.
//  base      in   ADDR_WIDTH     first fill address, latched on accepted start.
//  len       in   ADDR_WIDTH+1   word count, latched; 0..2**ADDR_WIDTH.
//  fill_val  in   DATA_WIDTH     fill word, latched on accepted start.
//  busy      out  1              high while in FILL.
//  done      out  1              one-cycle pulse when a fill completes.
//  cpu_req   in   1              CPU accesses RAM this cycle.
//  cpu_we    in   1              CPU write enable (qualified by cpu_req).
//  cpu_addr  in   ADDR_WIDTH     CPU address.
//  cpu_d     in   DATA_WIDTH     CPU write data.
//  cpu_q     out  DATA_WIDTH     CPU read data = ram_q, combinational.
//  cpu_stall out  1              combinational; CPU access denied this cycle, hold MEM stage.
//  ram_we    out  1              to ram.we.
//  ram_addr  out  ADDR_WIDTH     to ram.addr.
//  ram_d     out  DATA_WIDTH     to ram.d.
//  ram_q     in   DATA_WIDTH     from ram.q (asynchronous read).
// BEHAVIOUR
//  - States: IDLE, FILL. Internal: offset (ADDR_WIDTH+1 b), wait_cnt, latched base/len/val.
//  - Reset (rst=1 at edge): wait_cnt=0, offset=0, done=0.
//    CLEAR_ON_RESET=1: state=FILL, base=0, len=2**ADDR_WIDTH, val=0.
//    CLEAR_ON_RESET=0: state=IDLE.
//    A reset mid-fill aborts the fill immediately with no done pulse.
//  - IDLE: ram_* = cpu_addr/cpu_d, ram_we = cpu_req&cpu_we; cpu_stall=0; busy=0.
//    An idle fill port never writes.
//  - IDLE & start at edge t: latch inputs and enter FILL. The first fill write can occur in cycle t+1.
//    len=0: stay IDLE and pulse done in cycle t+1; no write.
//  - FILL, per cycle:
//    - If cpu_req and wait_cnt<MAX_WAIT: CPU owns the port, wait_cnt+=1, cpu_stall=0.
//    - Otherwise the fill owns the port: ram_we=1, ram_addr=(base+offset) mod 2**ADDR_WIDTH,
//      ram_d=val, offset+=1, wait_cnt=0. cpu_stall=cpu_req in this case.
//  - Completion: when the write with offset==len-1 is performed, the next state is IDLE.
//    done=1 for exactly that next cycle, with busy=0.
//    start is accepted in that same cycle.
//  - start while busy is ignored; no queueing.
//  - A CPU write and a fill write never share a cycle. Only the port owner drives ram_we.
//  - cpu_q always equals ram_q. During a fill-owned cycle, cpu_q content is don't-care; the CPU is stalled.
// TESTING
//  T1 AW=4, CLEAR_ON_RESET=1, rst 1 cycle, cpu_req=0 -> 16 writes of 0 to addr 0..15; busy 16 cyc; done in cycle 17.
//  T2 idle, start base=14 len=4 fill_val=32'hDEADBEEF -> writes to 14,15,0,1 in cycles 1-4; done in cycle 5.
//  T3 fill with cpu_req held 1, MAX_WAIT=3 -> repeating 3 CPU cycles then 1 fill cycle with cpu_stall=1; no starvation.
//  T4 start len=0 -> no ram_we from the fill; done=1 in next cycle; busy stays 0.
//  T5 start during FILL -> ignored, range unchanged. rst at offset 5 -> no write at that edge's cycle, restart per CLEAR_ON_RESET.
//  T6 IDLE cpu_req=1 cpu_we=1 addr=3 d=7, then read addr=3 -> cpu_q=7 in the same cycle as the read; cpu_stall=0 throughout.

Source files
------------

// File: rtl/ram_fill_arbiter.sv
// Arbitrates the single data-RAM port between the CPU MEM stage and a constant-fill
// engine. The engine clears the RAM after reset and also runs fills requested by software.
module ram_fill_arbiter #(
   parameter int ADDR_WIDTH     = 10,
   parameter int DATA_WIDTH     = 32,
   parameter int MAX_WAIT       = 3,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_i,
   input  logic [ADDR_WIDTH:0]   len_i,
   input  logic [DATA_WIDTH-1:0] fill_val_i,
   output logic                  busy_o,
   output logic                  done_o,
   input  logic                  cpu_req_i,
   input  logic                  cpu_we_i,
   input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
   input  logic [DATA_WIDTH-1:0] cpu_d_i,
   output logic [DATA_WIDTH-1:0] cpu_q_o,
   output logic                  cpu_stall_o,
   output logic                  ram_we_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [DATA_WIDTH-1:0] ram_d_o,
   input  logic [DATA_WIDTH-1:0] ram_q_i
);
   localparam int                  WAIT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0]   WAIT_MAX = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0]   WAIT_ONE = WAIT_W'(1);
   localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0] FULL_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic {S_IDLE, S_FILL} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH:0]     offset_q, offset_d;
   logic [WAIT_W-1:0]       wait_q, wait_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [ADDR_WIDTH:0]     len_q, len_d;
   logic [DATA_WIDTH-1:0]   val_q, val_d;
   logic                    done_q, done_d;
   logic                    fill_own;
   logic [ADDR_WIDTH-1:0]   fill_addr;

   // Address arithmetic wraps naturally at the top of the RAM.
   assign fill_addr = base_q + offset_q[ADDR_WIDTH-1:0];
   assign busy_o    = (state_q == S_FILL);
   assign done_o    = done_q;
   assign cpu_q_o   = ram_q_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         offset_q <= '0;
         wait_q   <= '0;
         done_q   <= 1'b0;
         if (CLEAR_ON_RESET) begin
            state_q <= S_FILL;
            base_q  <= '0;
            len_q   <= FULL_LEN;
            val_q   <= '0;
         end else begin
            state_q <= S_IDLE;
         end
      end else begin
         state_q  <= state_d;
         offset_q <= offset_d;
         wait_q   <= wait_d;
         base_q   <= base_d;
         len_q    <= len_d;
         val_q    <= val_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      wait_d   = wait_q;
      base_d   = base_q;
      len_d    = len_q;
      val_d    = val_q;
      done_d   = 1'b0;
      fill_own = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (len_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d  = S_FILL;
                  base_d   = base_i;
                  len_d    = len_i;
                  val_d    = fill_val_i;
                  offset_d = '0;
                  wait_d   = '0;
               end
            end
         end
         S_FILL: begin
            // The CPU wins until it has held the port MAX_WAIT cycles in a row.
            if (cpu_req_i && (wait_q < WAIT_MAX)) begin
               wait_d = wait_q + WAIT_ONE;
            end else begin
               fill_own = 1'b1;
               offset_d = offset_q + CNT_ONE;
               wait_d   = '0;
               if (offset_q == len_q - CNT_ONE) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      cpu_stall_o = fill_own & cpu_req_i;
      // A fill slot coinciding with reset is dropped so an aborted fill never writes.
      ram_we_o    = fill_own ? ~rst_i : (cpu_req_i & cpu_we_i);
      ram_addr_o  = fill_own ? fill_addr : cpu_addr_i;
      ram_d_o     = fill_own ? val_q : cpu_d_i;
   end
endmodule

// File: tb/tb_ram_fill_arbiter.sv
// Bench for ram_fill_arbiter: a RAM array behind the DUT plus a transaction-level model
// of the fill engine and arbitration, driven by directed and random stimulus.
module tb_ram_fill_arbiter;
   localparam int AW = 4;
   localparam int DW = 32;
   localparam int MW = 3;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst, start, cpu_req, cpu_we;
   logic [AW-1:0] base, cpu_addr;
   logic [AW:0]   len;
   logic [DW-1:0] fill_val, cpu_d;
   logic          busy_o, done_o, cpu_stall_o, ram_we_o;
   logic [AW-1:0] ram_addr_o;
   logic [DW-1:0] ram_d_o, cpu_q_o, ram_q;

   logic [DW-1:0] ram [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];

   int total = 0;
   int bad = 0;

   // Model state: pending fill described by range, words written and CPU win streak.
   bit  m_busy, m_done;
   int  m_base, m_len, m_cnt, m_streak;
   logic [DW-1:0] m_val;

   bit            exp_fw, exp_we, exp_rd;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_d, exp_q;
   logic [39:0]   exp_vec;
   wire  [39:0]   obs = {busy_o, done_o, cpu_stall_o, ram_we_o, ram_addr_o, ram_d_o};

   always #5 clk = ~clk;

   ram_fill_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW), .CLEAR_ON_RESET(1'b1)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .base_i(base), .len_i(len),
      .fill_val_i(fill_val), .busy_o(busy_o), .done_o(done_o), .cpu_req_i(cpu_req),
      .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_d_i(cpu_d), .cpu_q_o(cpu_q_o),
      .cpu_stall_o(cpu_stall_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
      .ram_d_o(ram_d_o), .ram_q_i(ram_q)
   );

   assign ram_q = ram[ram_addr_o];
   always @(posedge clk) if (ram_we_o === 1'b1) ram[ram_addr_o] <= ram_d_o;

   task automatic set_in(input bit r, input bit s, input int b, input int l, input logic [DW-1:0] v,
                         input bit rq, input bit we, input int a, input logic [DW-1:0] d);
      rst = r; start = s; base = AW'(b); len = (AW+1)'(l); fill_val = v;
      cpu_req = rq; cpu_we = we; cpu_addr = AW'(a); cpu_d = d;
   endtask

   task automatic predict();
      exp_fw   = m_busy && !(cpu_req && (m_streak < MW));
      exp_we   = exp_fw ? !rst : (cpu_req && cpu_we);
      exp_addr = exp_fw ? AW'((m_base + m_cnt) % DEPTH) : cpu_addr;
      exp_d    = exp_fw ? m_val : cpu_d;
      exp_vec  = {m_busy, m_done, exp_fw && cpu_req, exp_we, exp_addr, exp_d};
      exp_rd   = cpu_req && !cpu_we && !exp_fw;
      exp_q    = ref_mem[cpu_addr];
   endtask

   task automatic model_edge();
      bit nd = 1'b0;
      if (exp_we) ref_mem[exp_addr] = exp_d;
      if (rst) begin
         m_busy = 1'b1; m_done = 1'b0; m_base = 0; m_len = DEPTH; m_val = '0;
         m_cnt = 0; m_streak = 0;
      end else begin
         if (m_busy) begin
            if (exp_fw) begin
               m_cnt++; m_streak = 0;
               if (m_cnt == m_len) begin m_busy = 1'b0; nd = 1'b1; end
            end else begin
               m_streak++;
            end
         end else if (start) begin
            if (len == 0) nd = 1'b1;
            else begin
               m_busy = 1'b1; m_base = int'(base); m_len = int'(len); m_val = fill_val;
               m_cnt = 0; m_streak = 0;
            end
         end
         m_done = nd;
      end
   endtask

   task automatic test_reset();
      set_in(1, 0, 0, 0, '0, 0, 0, 0, '0);
      @(posedge clk); predict(); model_edge(); #1;
      for (int i = 0; i < 17; i++) begin
         set_in(0, 0, 0, 0, '0, 0, 0, 0, '0);
         predict(); #4; total++;
         if (obs !== exp_vec) begin bad++; $display("FAIL reset_clear cyc=%0d got=%h want=%h", i, obs, exp_vec); end
         @(posedge clk); model_edge(); #1;
      end
      for (int k = 0; k < DEPTH; k++) begin
         total++;
         if (ram[k] !== ref_mem[k]) begin bad++; $display("FAIL reset_mem addr=%0d got=%h want=%h", k, ram[k], ref_mem[k]); end
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 6; i++) begin
         set_in(0, i == 0, 14, 4, 32'hDEADBEEF, 0, 0, 0, '0);
         predict(); #4; total++;
         if (obs !== exp_vec) begin bad++; $display("FAIL wrap cyc=%0d got=%h want=%h", i, obs, exp_vec); end
         @(posedge clk); model_edge(); #1;
      end
   endtask

   task automatic test_len0();
      for (int i = 0; i < 3; i++) begin
         set_in(0, i == 0, 5, 0, 32'h12345678, 0, 0, 0, '0);
         predict(); #4; total++;
         if (obs !== exp_vec) begin bad++; $display("FAIL len0 cyc=%0d got=%h want=%h", i, obs, exp_vec); end
         @(posedge clk); model_edge(); #1;
      end
   endtask

   task automatic test_cpu_idle();
      for (int i = 0; i < 3; i++) begin
         set_in(0, 0, 0, 0, '0, i < 2, i == 0, 3, 32'd7);
         predict(); #4; total++;
         if (obs !== exp_vec) begin bad++; $display("FAIL cpu_idle cyc=%0d got=%h want=%h", i, obs, exp_vec); end
         if (exp_rd) begin
            total++;
            if (cpu_q_o !== exp_q) begin bad++; $display("FAIL cpu_idle_q cyc=%0d got=%h want=%h", i, cpu_q_o, exp_q); end
         end
         @(posedge clk); model_edge(); #1;
      end
   endtask

   task automatic test_starve();
      int stalls = 0;
      for (int i = 0; i < 40; i++) begin
         set_in(0, i == 0, $urandom_range(0, DEPTH - 1), 8, $urandom, 1, $urandom_range(0, 1),
                $urandom_range(0, DEPTH - 1), $urandom);
         predict(); #4; total++;
         if (obs !== exp_vec) begin bad++; $display("FAIL starve cyc=%0d got=%h want=%h", i, obs, exp_vec); end
         if (exp_rd) begin
            total++;
            if (cpu_q_o !== exp_q) begin bad++; $display("FAIL starve_q cyc=%0d got=%h want=%h", i, cpu_q_o, exp_q); end
         end
         if (cpu_stall_o === 1'b1) stalls++;
         @(posedge clk); model_edge(); #1;
      end
      total++;
      if (stalls != 8) begin bad++; $display("FAIL starve_slots got=%0d want=8", stalls); end
   endtask

   task automatic test_busy_start_reset();
      for (int i = 0; i < 25; i++) begin
         set_in(i == 6, (i == 0) || (i == 2), (i == 0) ? 6 : 0, (i == 0) ? 10 : 3,
                (i == 0) ? 32'hA5A5A5A5 : 32'h0BADF00D, 0, 0, 0, '0);
         predict(); #4; total++;
         if (obs !== exp_vec) begin bad++; $display("FAIL busy_rst cyc=%0d got=%h want=%h", i, obs, exp_vec); end
         @(posedge clk); model_edge(); #1;
      end
      for (int k = 0; k < DEPTH; k++) begin
         total++;
         if (ram[k] !== ref_mem[k]) begin bad++; $display("FAIL busy_rst_mem addr=%0d got=%h want=%h", k, ram[k], ref_mem[k]); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         set_in(0, (i < 320) && ($urandom_range(0, 5) == 0), $urandom_range(0, DEPTH - 1),
                ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, DEPTH), $urandom,
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom);
         predict(); #4; total++;
         if (obs !== exp_vec) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs, exp_vec); end
         if (exp_rd) begin
            total++;
            if (cpu_q_o !== exp_q) begin bad++; $display("FAIL random_q cyc=%0d got=%h want=%h", i, cpu_q_o, exp_q); end
         end
         @(posedge clk); model_edge(); #1;
      end
      for (int k = 0; k < DEPTH; k++) begin
         total++;
         if (ram[k] !== ref_mem[k]) begin bad++; $display("FAIL random_mem addr=%0d got=%h want=%h", k, ram[k], ref_mem[k]); end
      end
   endtask

   initial begin
      for (int k = 0; k < DEPTH; k++) begin
         ram[k] = $urandom;
         ref_mem[k] = ram[k];
      end
      m_busy = 1'b0; m_done = 1'b0; m_base = 0; m_len = 0; m_cnt = 0; m_streak = 0; m_val = '0;
      test_reset();
      test_wrap();
      test_len0();
      test_cpu_idle();
      test_starve();
      test_busy_start_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
